// File: rtl/mips_mc_core.sv
// mips_mc_core: multicycle MIPS subset core (R-type add/sub/and/or/slt, lw, sw, beq, addi, slti, j) on one unified memory port.
// Ports: clk, rst (sync, active-high); mem_adr/mem_wdata/mem_read/mem_write out, mem_rdata/mem_ready in;
// retire (one pulse per completed instruction), trap (sticky, illegal opcode/funct or memory timeout), pc_dbg (current PC).
// Params: RESET_PC (PC after reset), MEM_TIMEOUT (wait cycles before trap, 0 = never).
// Define MIPS_MC_CORE_LINK_EN to add jal and jr.
module mips_mc_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        mem_ready,
  output logic        retire,
  output logic        trap,
  output logic [31:0] pc_dbg
);
`ifdef MIPS_MC_CORE_LINK_EN
  localparam logic LINK_EN = 1'b1;
`else
  localparam logic LINK_EN = 1'b0;
`endif
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_ADDI = 6'h08, OP_SLTI = 6'h0a, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] F_JR = 6'h08, F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24,
                         F_OR = 6'h25, F_SLT = 6'h2a;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB, TRAP} state_t;
  state_t state, next;
  logic [31:0] pc, ir, a, b, alu_out, mdr, wcnt;
  logic [31:0] rf [32];
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, wb_dst;
  logic [31:0] imm, r_res, alu_res, wb_data;
  logic        is_r, is_jr, is_jal, legal, jump, access, timeout;
  assign op     = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign imm    = {{16{ir[15]}}, ir[15:0]};
  assign is_r   = op == OP_R;
  assign is_jr  = LINK_EN && is_r && funct == F_JR;
  assign is_jal = LINK_EN && op == OP_JAL;
  assign legal  = (is_r && funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT}) || is_jr || is_jal ||
                  op inside {OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SLTI, OP_J};
  // Control transfers complete in EXEC; everything else needs another state.
  assign jump   = op == OP_BEQ || op == OP_J || is_jal || is_jr;
  assign r_res  = funct == F_SUB ? a - b :
                  funct == F_AND ? a & b :
                  funct == F_OR  ? a | b :
                  funct == F_SLT ? {31'b0, $signed(a) < $signed(b)} : a + b;
  assign alu_res = is_r ? r_res : op == OP_SLTI ? {31'b0, $signed(a) < $signed(imm)} : a + imm;
  assign wb_dst  = is_r ? rd : rt;
  assign wb_data = op == OP_LW ? mdr : alu_out;
  assign access  = state == FETCH || state == MEM_RD || state == MEM_WR;
  // wcnt holds the number of ready-low cycles already spent on this access.
  assign timeout = MEM_TIMEOUT > 0 && !mem_ready && wcnt == 32'(MEM_TIMEOUT - 1);
  assign mem_adr   = (state == MEM_RD || state == MEM_WR) ? alu_out : pc;
  assign mem_wdata = state == MEM_WR ? b : '0;
  assign trap      = state == TRAP;
  assign pc_dbg    = pc;
  always_ff @(posedge clk)
    state <= rst ? FETCH : next;
  always_comb begin
    next      = state;
    retire    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state)
      FETCH: begin
        mem_read = 1'b1;
        next = mem_ready ? DECODE : timeout ? TRAP : FETCH;
      end
      DECODE: next = legal ? EXEC : TRAP;
      EXEC: begin
        retire = jump;
        next = jump ? FETCH : op == OP_LW ? MEM_RD : op == OP_SW ? MEM_WR : WB;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        next = mem_ready ? WB : timeout ? TRAP : MEM_RD;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        retire = mem_ready;
        next = mem_ready ? FETCH : timeout ? TRAP : MEM_WR;
      end
      WB: begin
        retire = 1'b1;
        next = FETCH;
      end
      default: next = TRAP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      ir <= '0;
      a <= '0;
      b <= '0;
      alu_out <= '0;
      mdr <= '0;
      wcnt <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      wcnt <= (access && !mem_ready) ? wcnt + 32'd1 : '0;
      case (state)
        FETCH: if (mem_ready) begin
          ir <= mem_rdata;
          pc <= pc + 32'd4;
        end
        DECODE: begin
          a <= rf[rs];
          b <= rf[rt];
        end
        EXEC: begin
          alu_out <= alu_res;
          if (op == OP_BEQ && a == b) pc <= pc + {imm[29:0], 2'b00};
          if (op == OP_J || is_jal) pc <= {pc[31:28], ir[25:0], 2'b00};
          if (is_jal) rf[31] <= pc;
          if (is_jr) pc <= a;
        end
        MEM_RD: if (mem_ready) mdr <= mem_rdata;
        WB: if (wb_dst != 5'd0) rf[wb_dst] <= wb_data;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_mc_core.sv
// tb_mips_mc_core: directed-program bench for mips_mc_core with a small unified memory model.
module tb_mips_mc_core;
  localparam logic [31:0] NOP = 32'h2000_0000;
  logic        clk, rst;
  logic [31:0] mem_adr, mem_wdata, mem_rdata, pc_dbg;
  logic        mem_read, mem_write, mem_ready, retire, trap;
  logic [31:0] mem [128];
  logic [31:0] st_adr, st_data;
  logic        st_valid, hang;
  int          wait_n, tw, n_store, n_vec, n_bad, cyc;
  int          rq[$];

  mips_mc_core dut (
    .clk(clk), .rst(rst), .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready),
    .retire(retire), .trap(trap), .pc_dbg(pc_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_ready = (mem_read || mem_write) && !hang && tw >= wait_n;
  assign mem_rdata = (st_valid && mem_adr == st_adr) ? st_data : mem[mem_adr[8:2]];

  always @(posedge clk) begin
    tw <= (rst || !(mem_read || mem_write) || mem_ready) ? 0 : tw + 1;
    if (rst) st_valid <= 1'b0;
    else if (mem_write && mem_ready) begin
      st_valid <= 1'b1;
      st_adr   <= mem_adr;
      st_data  <= mem_wdata;
      n_store  <= n_store + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1);
  end

  function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] rtype(logic [4:0] rd, logic [4:0] rs, logic [4:0] rt, logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear();
    for (int i = 0; i < 128; i++) mem[i] = NOP;
  endtask

  task automatic step();
    if (retire) rq.push_back(cyc);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 1;
    rq.delete();
  endtask

  task automatic run_to(string tag, int n, int budget);
    int k = 0;
    while (rq.size() < n && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_retired"}, rq.size(), n);
  endtask

  initial begin
    int s0;
    n_vec = 0; n_bad = 0; n_store = 0; tw = 0; st_valid = 1'b0;
    st_adr = '0; st_data = '0; hang = 1'b0; wait_n = 0; rst = 1'b1;

    // addi/addi/add with zero-wait memory, plus reset-state outputs
    clear();
    mem[0] = itype(6'h08, 0, 1, 16'd5);
    mem[1] = itype(6'h08, 0, 2, 16'hFFFD);
    mem[2] = rtype(3, 1, 2, 6'h20);
    do_reset();
    chk("rst_mem_read", mem_read, 1);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_retire", retire, 0);
    chk("rst_trap", trap, 0);
    chk("rst_mem_adr", mem_adr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    run_to("add", 3, 40);
    chk("ret0_cycle", rq[0], 4);
    chk("ret1_cycle", rq[1], 8);
    chk("ret2_cycle", rq[2], 12);
    chk("r2_neg", dut.rf[2], 32'hFFFF_FFFD);
    chk("r3_sum", dut.rf[3], 32'd2);

    // ALU ops: sub, and, or, slt both ways, slti both ways
    clear();
    mem[0] = itype(6'h08, 0, 1, 16'd5);
    mem[1] = itype(6'h08, 0, 2, 16'hFFFD);
    mem[2] = rtype(3, 1, 2, 6'h22);
    mem[3] = rtype(4, 1, 2, 6'h24);
    mem[4] = rtype(5, 1, 2, 6'h25);
    mem[5] = rtype(6, 2, 1, 6'h2a);
    mem[6] = rtype(7, 1, 2, 6'h2a);
    mem[7] = itype(6'h0a, 2, 8, 16'd0);
    mem[8] = itype(6'h0a, 1, 9, 16'd5);
    do_reset();
    run_to("alu", 9, 60);
    chk("sub", dut.rf[3], 32'd8);
    chk("and", dut.rf[4], 32'd5);
    chk("or", dut.rf[5], 32'hFFFF_FFFD);
    chk("slt_true", dut.rf[6], 32'd1);
    chk("slt_false", dut.rf[7], 32'd0);
    chk("slti_true", dut.rf[8], 32'd1);
    chk("slti_false", dut.rf[9], 32'd0);

    // sw then lw with two wait cycles per access
    clear();
    mem[0] = itype(6'h08, 0, 3, 16'd2);
    mem[3] = itype(6'h2b, 0, 3, 16'd8);
    mem[4] = itype(6'h23, 0, 4, 16'd8);
    wait_n = 2;
    s0 = n_store;
    do_reset();
    run_to("swlw", 5, 80);
    chk("addi_wait_cycle", rq[0], 6);
    chk("sw_cycles", rq[3] - rq[2], 8);
    chk("lw_cycles", rq[4] - rq[3], 9);
    chk("store_count", n_store - s0, 1);
    chk("store_adr", st_adr, 32'd8);
    chk("store_data", st_data, 32'd2);
    chk("lw_r4", dut.rf[4], 32'd2);
    wait_n = 0;

    // taken beq loops at 0x10 every 3 cycles
    clear();
    mem[4] = itype(6'h04, 1, 1, 16'hFFFF);
    do_reset();
    run_to("beq_t", 5, 40);
    chk("beq_t_pc", pc_dbg, 32'h10);
    chk("beq_t_cycle", rq[4], 19);
    run_to("beq_t2", 6, 10);
    chk("beq_t_period", rq[5] - rq[4], 3);
    chk("beq_t_pc2", pc_dbg, 32'h10);

    // untaken beq falls through to 0x14
    clear();
    mem[0] = itype(6'h08, 0, 1, 16'd1);
    mem[4] = itype(6'h04, 1, 2, 16'd5);
    do_reset();
    run_to("beq_n", 5, 40);
    chk("beq_n_pc", pc_dbg, 32'h14);

    // illegal opcode: sticky trap, PC frozen, reset recovers
    clear();
    mem[0] = 32'hFC00_0000;
    do_reset();
    step(); step();
    chk("op_trap", trap, 1);
    chk("op_trap_rd", mem_read, 0);
    for (int i = 0; i < 6; i++) step();
    chk("op_trap_sticky", trap, 1);
    chk("op_trap_rd2", mem_read, 0);
    chk("op_trap_wr", mem_write, 0);
    chk("op_trap_pc", pc_dbg, 32'h4);
    chk("op_trap_noret", rq.size(), 0);
    do_reset();
    chk("op_trap_rst_pc", pc_dbg, 32'h0);
    chk("op_trap_rst_trap", trap, 0);

    // illegal funct
    clear();
    mem[0] = rtype(1, 0, 0, 6'h27);
    do_reset();
    step(); step();
    chk("fn_trap", trap, 1);

    // memory timeout after 16 ready-low cycles
    clear();
    hang = 1'b1;
    do_reset();
    for (int i = 0; i < 15; i++) step();
    chk("to_edge_trap", trap, 0);
    chk("to_edge_rd", mem_read, 1);
    step();
    chk("to_trap", trap, 1);
    chk("to_trap_rd", mem_read, 0);
    hang = 1'b0;
    step(); step(); step();
    chk("to_sticky", trap, 1);
    chk("to_sticky_rd", mem_read, 0);
    do_reset();
    chk("to_rst_trap", trap, 0);
    chk("to_rst_pc", pc_dbg, 32'h0);

    // jal / jr
    clear();
    mem[2]  = {6'h03, 26'h40};
    mem[64] = {6'h00, 5'd31, 15'd0, 6'h08};
    do_reset();
`ifdef MIPS_MC_CORE_LINK_EN
    run_to("jal", 3, 40);
    chk("jal_cycle", rq[2], 11);
    chk("jal_pc", pc_dbg, 32'h100);
    chk("jal_r31", dut.rf[31], 32'hC);
    run_to("jr", 4, 20);
    chk("jr_cycles", rq[3] - rq[2], 3);
    chk("jr_pc", pc_dbg, 32'hC);
`else
    run_to("jal", 2, 40);
    step(); step();
    chk("jal_trap", trap, 1);
    chk("jal_trap_rd", mem_read, 0);
`endif

    // writes to r0 are dropped
    clear();
    mem[0] = itype(6'h08, 0, 0, 16'd7);
    mem[1] = itype(6'h08, 0, 5, 16'd1);
    do_reset();
    run_to("r0", 2, 20);
    chk("r0_zero", dut.rf[0], 32'd0);
    chk("r0_read", dut.rf[5], 32'd1);

    // reset in the middle of a stalled store
    clear();
    mem[0] = itype(6'h08, 0, 3, 16'd9);
    mem[1] = itype(6'h2b, 0, 3, 16'h40);
    wait_n = 10;
    s0 = n_store;
    do_reset();
    for (int k = 0; k < 80 && !mem_write; k++) step();
    chk("mw_seen", mem_write, 1);
    step(); step();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mw_rst_wr", mem_write, 0);
    chk("mw_rst_rd", mem_read, 1);
    chk("mw_rst_ret", retire, 0);
    chk("mw_rst_adr", mem_adr, 32'h0);
    chk("mw_rst_wdata", mem_wdata, 32'h0);
    chk("mw_no_store", n_store - s0, 0);
    rst = 1'b0;
    wait_n = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mips_mc_core.md
MIPS_MC_CORE -- requirements
Module: mips_mc_core

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The module SHALL have parameter MEM_TIMEOUT, default 16, meaning the maximum number of wait cycles per memory access before trap; 0 disables the timeout.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-005 The module SHALL have port mem_adr, output, 32, the unified instruction/data byte address.
REQ-006 The module SHALL have port mem_wdata, output, 32, the store data.
REQ-007 The module SHALL have port mem_rdata, input, 32, the read data, valid when mem_ready=1.
REQ-008 The module SHALL have ports mem_read and mem_write, output, 1 each, the access requests; never both high.
REQ-009 The module SHALL have port mem_ready, input, 1, which completes the current access in the cycle it is high.
REQ-010 The module SHALL have port retire, output, 1, a one-cycle pulse per completed instruction.
REQ-011 The module SHALL have port trap, output, 1, high in TRAP state (illegal opcode or memory timeout).
REQ-012 The module SHALL have port pc_dbg, output, 32, the current PC.

Function
REQ-013 The module SHALL implement a multicycle FSM with states FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB, TRAP.
REQ-014 In FETCH the module SHALL drive mem_read=1, mem_adr=PC; while mem_ready=0 it holds, and on mem_ready=1 it latches IR<=mem_rdata, sets PC<=PC+4 and goes to DECODE.
REQ-015 In DECODE the module SHALL latch A<=rf[rs], B<=rf[rt] and sign-extended imm.
REQ-016 A decoded opcode outside {R-type, lw, sw, beq, addi, slti, j} (plus jal and R-type funct jr under REQ-034) SHALL go to TRAP.
REQ-017 An R-type instruction SHALL accept funct add, sub, and, or, slt (jr per REQ-034); any other funct SHALL go to TRAP.
REQ-018 In EXEC, R-type, addi and slti SHALL compute ALUOut and go to WB; lw and sw SHALL compute A+imm and go to MEM_RD or MEM_WR respectively.
REQ-019 In EXEC, beq SHALL set PC<=PC+(imm<<2) if A==B, then retire and go to FETCH.
REQ-020 In EXEC, j SHALL set PC<={PC[31:28],target,2'b00}, then retire and go to FETCH.
REQ-021 MEM_RD SHALL drive mem_read=1, mem_adr=ALUOut and hold until mem_ready; the read data SHALL be latched into MDR before going to WB.
REQ-022 MEM_WR SHALL drive mem_write=1, mem_adr=ALUOut, mem_wdata=B and hold until mem_ready; it SHALL then retire and go to FETCH.
REQ-023 WB SHALL write rd (R-type) or rt (addi, slti) with ALUOut, or rt (lw) with MDR; it SHALL then retire and go to FETCH.
REQ-024 Writes to register 0 SHALL be discarded, and register 0 SHALL always read 0.
REQ-025 All arithmetic SHALL be 32-bit modulo 2^32 with overflow ignored; slt and slti SHALL be signed comparisons.
REQ-026 Cycle counts with zero-wait memory SHALL be: beq and j 3; R-type, addi, slti and sw 4; lw 5. Each mem_ready=0 cycle SHALL add one cycle.
REQ-027 A wait counter SHALL reset at each access start; when MEM_TIMEOUT>0 and MEM_TIMEOUT consecutive mem_ready=0 cycles elapse, the FSM SHALL go to TRAP.
REQ-028 TRAP SHALL be sticky: mem_read=mem_write=0, PC frozen, left only by rst.
REQ-029 retire SHALL be low in every cycle other than the single completion cycle of an instruction.

Reset
REQ-030 While rst=1 at a rising edge, the module SHALL load state=FETCH, PC=RESET_PC, IR=A=B=ALUOut=MDR=0, wait counter=0 and all 32 registers=0.
REQ-031 Reset SHALL override any in-flight access with no write committed; the outputs after reset SHALL be mem_read=1 (FETCH), mem_write=0, retire=0, trap=0, mem_adr=RESET_PC, mem_wdata=0.

Configuration
REQ-032 The macro MIPS_MC_CORE_LINK_EN SHALL compile link-jump support in or out.
REQ-033 With MIPS_MC_CORE_LINK_EN defined, jal (opcode 6'h03) in EXEC SHALL write r31<=PC (already PC+4), jump as j does, and retire (3 cycles).
REQ-034 With MIPS_MC_CORE_LINK_EN defined, jr (funct 6'h08) in EXEC SHALL set PC<=A and retire (3 cycles).
REQ-035 Without MIPS_MC_CORE_LINK_EN, opcode 6'h03 and funct 6'h08 SHALL go to TRAP.

Verification
REQ-036 Bench: addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2 with zero-wait memory -> r3=2, retire pulses at cycles 4, 8, 12 after reset release.
REQ-037 Bench: sw r3,8(r0) then lw r4,8(r0) with mem_ready delayed 2 cycles per access -> write of 2 to address 8, r4=2, lw takes 5+4=9 cycles.
REQ-038 Bench: beq r1,r1,-1 at PC 0x10 -> PC returns to 0x10 every 3 cycles; beq with A!=B -> next PC 0x14.
REQ-039 Bench: fetch opcode 6'h3F, and separately mem_ready held low 16 cycles with MEM_TIMEOUT=16 -> trap=1 and mem_read=0 until rst; rst then gives PC=RESET_PC.
REQ-040 Bench: jal 0x40 at PC 0x8 then jr r31 -> r31=0xC, PC=0x100, then PC=0xC with the macro defined; trap=1 at jal without it.
REQ-041 Bench: addi r0,r0,7 -> r0 reads 0; rst asserted mid-MEM_WR -> mem_write=0 next cycle and no store retired.
